// File: rtl/onehot_decoder_pipe.sv
// Binary index to one-hot decoder with valid/ready handshake, registered output and one-entry skid.
// Optional macro ONEHOT_DECODER_PIPE_CHECK_EN enables dec_err and a one-hot sanity assertion.
module onehot_decoder_pipe #(
    parameter  int unsigned WIDTH     = 32,
    localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_vld,
    output logic                 enc_rdy,
    input  logic [WIDTH_LOG-1:0] enc_idx,
    input  logic                 enc_ena,
    output logic                 dec_vld,
    input  logic                 dec_rdy,
    output logic [WIDTH-1:0]     dec_oht,
    output logic                 dec_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] oht_c;
    logic             err_c;
    logic [WIDTH-1:0] skid_oht;
    logic             skid_err;
    logic             in_xfer_c;
    logic             out_xfer_c;

    assign in_xfer_c  = enc_vld && enc_rdy;
    assign out_xfer_c = dec_vld && dec_rdy;

    // Decode ahead of the registers; out-of-range indices match no bit and yield all-zero.
    always_comb begin
        oht_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            oht_c[i] = enc_ena && (32'(enc_idx) == i);
        end
    end

`ifdef ONEHOT_DECODER_PIPE_CHECK_EN
    // An enabled word that selects nothing can only mean the index is out of range.
    assign err_c = enc_ena && (oht_c == '0);
`else
    assign err_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            enc_rdy  <= 1'b1;
            dec_vld  <= 1'b0;
            dec_oht  <= '0;
            dec_err  <= 1'b0;
            skid_oht <= '0;
            skid_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer_c) begin
                        state   <= ONE;
                        dec_vld <= 1'b1;
                        dec_oht <= oht_c;
                        dec_err <= err_c;
                    end
                end
                ONE: begin
                    if (in_xfer_c && out_xfer_c) begin
                        dec_oht <= oht_c;
                        dec_err <= err_c;
                    end else if (out_xfer_c) begin
                        state   <= EMPTY;
                        dec_vld <= 1'b0;
                    end else if (in_xfer_c) begin
                        state    <= FULL;
                        enc_rdy  <= 1'b0;
                        skid_oht <= oht_c;
                        skid_err <= err_c;
                    end
                end
                FULL: begin
                    // Skid drains into the output register as soon as downstream takes the head.
                    if (out_xfer_c) begin
                        state   <= ONE;
                        enc_rdy <= 1'b1;
                        dec_oht <= skid_oht;
                        dec_err <= skid_err;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    enc_rdy <= 1'b1;
                    dec_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef ONEHOT_DECODER_PIPE_CHECK_EN
    a_onehot0 : assert property (@(posedge clk) disable iff (rst) dec_vld |-> $onehot0(dec_oht));
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: directed cases at WIDTH=24, then random stalls at WIDTH=24 and 32
// against a queue-based reference model.
module tb_onehot_decoder_pipe;

    localparam int unsigned N_RAND    = 5000;
    localparam int unsigned CYC_LIMIT = 40000;
`ifdef ONEHOT_DECODER_PIPE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_vld = 1'b0, a_erdy, a_ena = 1'b0, a_dvld, a_drdy = 1'b0, a_err;
    logic [4:0]  a_idx = '0;
    logic [23:0] a_oht;
    logic        b_vld = 1'b0, b_erdy, b_ena = 1'b0, b_dvld, b_drdy = 1'b0, b_err;
    logic [4:0]  b_idx = '0;
    logic [31:0] b_oht;

    int checks = 0;
    int errors = 0;

    onehot_decoder_pipe #(.WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst),
        .enc_vld(a_vld), .enc_rdy(a_erdy), .enc_idx(a_idx), .enc_ena(a_ena),
        .dec_vld(a_dvld), .dec_rdy(a_drdy), .dec_oht(a_oht), .dec_err(a_err)
    );

    onehot_decoder_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .enc_vld(b_vld), .enc_rdy(b_erdy), .enc_idx(b_idx), .enc_ena(b_ena),
        .dec_vld(b_dvld), .dec_rdy(b_drdy), .dec_oht(b_oht), .dec_err(b_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {err, one-hot} straight from the decode rule.
    function automatic logic [32:0] ref_word(input int unsigned w, input int unsigned idx, input bit ena);
        logic [31:0] v;
        logic        e;
        v = '0;
        e = 1'b0;
        if (ena) begin
            if (idx < w) v = 32'(1) << idx;
            else         e = CHK_EN;
        end
        return {e, v};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset state and single decode
        check("rst_vld", 64'(a_dvld), 64'(0));
        check("rst_rdy", 64'(a_erdy), 64'(1));
        check("rst_oht", 64'(a_oht), 64'(0));
        check("rst_err", 64'(a_err), 64'(0));
        a_vld = 1'b1; a_idx = 5'd5; a_ena = 1'b1; a_drdy = 1'b1;
        step();
        check("t1_vld", 64'(a_dvld), 64'(1));
        check("t1_oht", 64'(a_oht), 64'h20);
        check("t1_err", 64'(a_err), 64'(0));
        a_vld = 1'b0;
        step();

        // 2: back-to-back stream
        for (int i = 0; i < 24; i++) begin
            a_vld = 1'b1; a_idx = 5'(i);
            step();
            check("t2_rdy", 64'(a_erdy), 64'(1));
            check("t2_vld", 64'(a_dvld), 64'(1));
            check("t2_oht", 64'(a_oht), 64'(32'(1) << i));
        end
        a_vld = 1'b0;
        step();
        check("t2_drain", 64'(a_dvld), 64'(0));

        // 3: backpressure fills the skid
        a_drdy = 1'b0;
        a_vld = 1'b1; a_idx = 5'd3;
        step();
        a_idx = 5'd7;
        step();
        check("t3_rdy_full", 64'(a_erdy), 64'(0));
        check("t3_oht_a", 64'(a_oht), 64'h8);
        a_vld = 1'b0;
        step();
        check("t3_hold", 64'({a_dvld, a_oht}), 64'({1'b1, 24'h8}));
        a_drdy = 1'b1;
        step();
        check("t3_oht_b", 64'(a_oht), 64'h80);
        check("t3_rdy_back", 64'(a_erdy), 64'(1));
        step();
        check("t3_empty", 64'(a_dvld), 64'(0));

        // 4: out-of-range index
        a_vld = 1'b1; a_idx = 5'd26; a_ena = 1'b1;
        step();
        check("t4_vld", 64'(a_dvld), 64'(1));
        check("t4_oht", 64'(a_oht), 64'(0));
        check("t4_err", 64'(a_err), 64'(CHK_EN));
        a_vld = 1'b0;
        step();

        // 5: no-selection word
        a_vld = 1'b1; a_idx = 5'd9; a_ena = 1'b0;
        step();
        check("t5_vld", 64'(a_dvld), 64'(1));
        check("t5_oht", 64'(a_oht), 64'(0));
        check("t5_err", 64'(a_err), 64'(0));
        a_vld = 1'b0; a_ena = 1'b1;
        step();

        // 6: reset while FULL discards both words
        a_drdy = 1'b0;
        a_vld = 1'b1; a_idx = 5'd4;
        step();
        a_idx = 5'd6;
        step();
        check("t6_full", 64'(a_erdy), 64'(0));
        a_vld = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_vld", 64'(a_dvld), 64'(0));
        check("t6_rst_rdy", 64'(a_erdy), 64'(1));
        a_drdy = 1'b1; a_vld = 1'b1; a_idx = 5'd1;
        step();
        check("t6_oht", 64'(a_oht), 64'h2);
        a_vld = 1'b0;
        step();
        check("t6_no_stale", 64'(a_dvld), 64'(0));

        // Random stalls on both widths
        fork
            begin : rand_a
                int unsigned sent, got, cyc;
                logic [32:0] q[$];
                logic [32:0] e, held;
                logic        hold;
                sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
                while (got < N_RAND && cyc < CYC_LIMIT) begin
                    if (hold) check("a_hold", 64'({a_dvld, a_err, 32'(a_oht)}), 64'({1'b1, held}));
                    a_vld  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
                    a_idx  = 5'($urandom_range(0, 31));
                    a_ena  = ($urandom_range(0, 7) != 0);
                    a_drdy = ($urandom_range(0, 3) != 0);
                    if (a_vld && a_erdy) begin
                        q.push_back(ref_word(24, a_idx, a_ena));
                        sent++;
                    end
                    if (a_dvld && a_drdy) begin
                        got++;
                        if (q.size() == 0) check("a_extra", 64'(1), 64'(0));
                        else begin
                            e = q.pop_front();
                            check("a_word", 64'({a_err, 32'(a_oht)}), 64'(e));
                        end
                    end
                    hold = a_dvld && !a_drdy;
                    held = {a_err, 32'(a_oht)};
                    step();
                    cyc++;
                end
                a_vld = 1'b0;
                check("a_count", 64'(got), 64'(N_RAND));
                check("a_left", 64'(q.size()), 64'(0));
            end
            begin : rand_b
                int unsigned sent, got, cyc;
                logic [32:0] q[$];
                logic [32:0] e, held;
                logic        hold;
                sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
                while (got < N_RAND && cyc < CYC_LIMIT) begin
                    if (hold) check("b_hold", 64'({b_dvld, b_err, b_oht}), 64'({1'b1, held}));
                    b_vld  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
                    b_idx  = 5'($urandom_range(0, 31));
                    b_ena  = ($urandom_range(0, 7) != 0);
                    b_drdy = ($urandom_range(0, 2) != 0);
                    if (b_vld && b_erdy) begin
                        q.push_back(ref_word(32, b_idx, b_ena));
                        sent++;
                    end
                    if (b_dvld && b_drdy) begin
                        got++;
                        if (q.size() == 0) check("b_extra", 64'(1), 64'(0));
                        else begin
                            e = q.pop_front();
                            check("b_word", 64'({b_err, b_oht}), 64'(e));
                        end
                    end
                    hold = b_dvld && !b_drdy;
                    held = {b_err, b_oht};
                    step();
                    cyc++;
                end
                b_vld = 1'b0;
                check("b_count", 64'(got), 64'(N_RAND));
                check("b_left", 64'(q.size()), 64'(0));
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
